// File: rtl/glyph_blitter_pkg.sv
// Shared glyph geometry, screen size and FSM state encoding
// for the glyph blitter and its row shifter.
package glyph_blitter_pkg;

  localparam int G_GLYPH_W  = 24;
  localparam int G_ROW_BITS = 3;
  localparam int G_GLYPH_H  = 2 ** G_ROW_BITS;
  localparam int G_SCREEN_W = 640;
  localparam int G_SCREEN_H = 480;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAW,
    S_FIN
  } state_e;

endpackage

// File: rtl/glyph_row_shifter.sv
// Holds one glyph row word; presents the current pixel bit (MSB)
// and flags the last column of the row.
module glyph_row_shifter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         adv_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o,
  output logic         last_col_o
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [W-1:0]  sh_q;
  logic [CW-1:0] col_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      col_q <= '0;
    end else if (load_i) begin
      sh_q  <= data_i;
      col_q <= '0;
    end else if (adv_i) begin
      sh_q  <= {sh_q[W-2:0], 1'b0};
      col_q <= col_q + CW'(1);
    end
  end

  assign msb_o      = sh_q[W-1];
  assign last_col_o = (col_q == LAST);

endmodule

// File: rtl/glyph_blitter.sv
// Reads a glyph row by row from the glyph ROM and writes its pixels
// into the framebuffer write port, with clipping and transparency.
module glyph_blitter
  import glyph_blitter_pkg::*;
#(
  parameter int DATA_WIDTH    = G_GLYPH_W,
  parameter int ADDR_WIDTH    = 8,
  parameter int ROW_BITS      = G_ROW_BITS,
  parameter int SCREEN_W      = G_SCREEN_W,
  parameter int SCREEN_H      = G_SCREEN_H,
  parameter int FB_ADDR_WIDTH = 19,
  parameter int COLOR_WIDTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [9:0]                   req_x,
  input  logic [9:0]                   req_y,
  input  logic [ADDR_WIDTH-ROW_BITS-1:0] req_glyph,
  input  logic [COLOR_WIDTH-1:0]       req_fg,
  input  logic [COLOR_WIDTH-1:0]       req_bg,
  input  logic                         req_transp,
  output logic [ADDR_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_q,
  output logic                         fb_we,
  output logic [FB_ADDR_WIDTH-1:0]     fb_addr,
  output logic [COLOR_WIDTH-1:0]       fb_data,
  input  logic                         fb_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int GW      = ADDR_WIDTH - ROW_BITS;
  localparam int GLYPH_H = 2 ** ROW_BITS;
  localparam int FA      = FB_ADDR_WIDTH;

  state_e                  state_q;
  logic [ROW_BITS-1:0]     row_q;
  logic [GW-1:0]           glyph_q;
  logic [9:0]              x_q;
  logic [10:0]             xc_q;
  logic [10:0]             yc_q;
  logic [COLOR_WIDTH-1:0]  fg_q;
  logic [COLOR_WIDTH-1:0]  bg_q;
  logic                    transp_q;
  logic [FA-1:0]           base_q;
  logic [FA-1:0]           pix_q;
  logic [ADDR_WIDTH-1:0]   rom_addr_q;

  logic          bit_w;
  logic          last_w;
  logic          clip_w;
  logic          adv_w;
  logic [FA-1:0] start_w;
  logic [FA-1:0] next_base_w;

  assign clip_w = (xc_q >= 11'(SCREEN_W)) ||
                  (yc_q >= 11'(SCREEN_H));

  assign fb_we = (state_q == S_DRAW) && !clip_w &&
                 (bit_w || !transp_q);

  // Skipped pixels advance unconditionally; writes wait for fb_ready.
  assign adv_w = (state_q == S_DRAW) && (!fb_we || fb_ready);

  assign start_w = FA'(req_y) * FA'(SCREEN_W) + FA'(req_x);
  assign next_base_w = base_q + FA'(SCREEN_W);

  glyph_row_shifter #(
    .W (DATA_WIDTH)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == S_WAIT),
    .adv_i      (adv_w),
    .data_i     (rom_q),
    .msb_o      (bit_w),
    .last_col_o (last_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      glyph_q    <= '0;
      x_q        <= '0;
      xc_q       <= '0;
      yc_q       <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      transp_q   <= 1'b0;
      base_q     <= '0;
      pix_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (req_valid) begin
          state_q    <= S_FETCH;
          row_q      <= '0;
          glyph_q    <= req_glyph;
          x_q        <= req_x;
          xc_q       <= {1'b0, req_x};
          yc_q       <= {1'b0, req_y};
          fg_q       <= req_fg;
          bg_q       <= req_bg;
          transp_q   <= req_transp;
          base_q     <= start_w;
          pix_q      <= start_w;
          rom_addr_q <= {req_glyph, ROW_BITS'(0)};
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT:  state_q <= S_DRAW;
        S_DRAW: if (adv_w) begin
          if (!last_w) begin
            xc_q  <= xc_q + 11'(1);
            pix_q <= pix_q + FA'(1);
          end else if (row_q == ROW_BITS'(GLYPH_H - 1)) begin
            state_q <= S_FIN;
          end else begin
            state_q    <= S_FETCH;
            row_q      <= row_q + ROW_BITS'(1);
            rom_addr_q <= {glyph_q, row_q + ROW_BITS'(1)};
            xc_q       <= {1'b0, x_q};
            yc_q       <= yc_q + 11'(1);
            base_q     <= next_base_w;
            pix_q      <= next_base_w;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);
  assign rom_addr  = rom_addr_q;
  assign fb_addr   = pix_q;
  assign fb_data   = bit_w ? fg_q : bg_q;

endmodule
